// File: rtl/mccoy_sequencer.sv
// McCoy CPU multi-cycle sequencer: IDLE -> FETCH -> DECODE -> EXECUTE, with a sticky fetch-timeout FAULT.
// Optional MCCOY_SINGLE_STEP_EN adds a step input that gates IDLE->FETCH and forces EXECUTE back to IDLE.
module mccoy_sequencer #(
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
`ifdef MCCOY_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [7:0]       imem_data,
    output logic [7:0]       ir,
    input  logic             dec_bez,
    input  logic             dec_ja,
    input  logic             dec_wreg,
    input  logic             dec_wx8,
    input  logic             x8_zero,
    output logic             reg_we,
    output logic             x8_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (FETCH_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            start_ok;
    logic            exec_to_fetch;
    logic            fetch_expired;
    logic            take_branch;

    function automatic logic resolve_pc_load(input logic bez, input logic ja, input logic zero);
        return ja | (bez & zero);
    endfunction

`ifdef MCCOY_SINGLE_STEP_EN
    assign start_ok      = run & step;
    assign exec_to_fetch = 1'b0;
`else
    assign start_ok      = run;
    assign exec_to_fetch = run;
`endif

    assign fetch_expired = TO_EN && (to_cnt == TO_LAST);
    assign take_branch   = resolve_pc_load(dec_bez, dec_ja, x8_zero);
    assign state_o       = state;

    // Strobes are decoded from the current state and inputs, and forced low during reset.
    always_comb begin
        imem_req = 1'b0;
        reg_we   = 1'b0;
        x8_we    = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: imem_req = 1'b1;
                S_EXECUTE: begin
                    reg_we  = dec_wreg;
                    x8_we   = dec_wx8;
                    pc_load = take_branch;
                    pc_inc  = ~take_branch;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ir          <= '0;
            instr_count <= '0;
            to_cnt      <= '0;
            fault       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir     <= imem_data;
                        to_cnt <= '0;
                        state  <= S_DECODE;
                    end else if (fetch_expired) begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DECODE: state <= S_EXECUTE;
                S_EXECUTE: begin
                    instr_count <= instr_count + 1'b1;
                    state       <= exec_to_fetch ? S_FETCH : S_IDLE;
                end
                S_FAULT: fault <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
